// File: rtl/battle_turn_if.sv
// Turn-sequencer bus between the input/HUD side and the battle damage engine.
// master drives engine status and key events; slave is battle_turn_ctrl.
interface battle_turn_if;
    logic       battle_active;
    logic       btn_valid;
    logic [1:0] btn_code;
    logic [1:0] player_bats;
    logic [1:0] player_swords;
    logic [1:0] enemy_bats;
    logic [1:0] enemy_swords;
    logic [7:0] player_hp;
    logic       player_win;
    logic       enemy_win;
    logic       player_turn;
    logic [1:0] player_choice;
    logic       attacker_turn;
    logic [1:0] enemy_choice;
    logic       await_input;
    logic       reject;
    logic [7:0] round_count;

    modport master (
        output battle_active, btn_valid, btn_code,
        output player_bats, player_swords, enemy_bats, enemy_swords,
        output player_hp, player_win, enemy_win,
        input  player_turn, player_choice, attacker_turn, enemy_choice,
        input  await_input, reject, round_count
    );

    modport slave (
        input  battle_active, btn_valid, btn_code,
        input  player_bats, player_swords, enemy_bats, enemy_swords,
        input  player_hp, player_win, enemy_win,
        output player_turn, player_choice, attacker_turn, enemy_choice,
        output await_input, reject, round_count
    );
endinterface

// File: rtl/battle_turn_ctrl.sv
// Turn sequencer: player key press -> player strike -> settle -> LFSR enemy strike -> settle.
// Define ENEMY_SMART_EN to let the enemy pick heavy weapons when the player is low on HP.
//
// state  | meaning
// S_IDLE | not in contact, waiting for battle_active
// S_WAIT | prompting player, accepting attack key
// S_PHIT | player_turn strike pulse
// S_PDLY | settle delay after player strike
// S_EHIT | attacker_turn strike pulse, enemy_choice valid
// S_EDLY | settle delay after enemy strike
// S_DONE | winner reported, frozen until contact ends
module battle_turn_ctrl #(
    parameter int          RESP_DELAY = 50_000_000,
    parameter int          CNT_W      = 27,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    battle_turn_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_PHIT, S_PDLY, S_EHIT, S_EDLY, S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_lfsr;
    logic [1:0]       r_player_choice;
    logic [1:0]       r_enemy_choice;
    logic             r_reject;
    logic [7:0]       r_round;

    logic             w_win;
    logic             w_term;
    logic             w_illegal;
    logic             w_accept;
    logic             w_refuse;
    logic             w_ehit_entry;
    logic             w_round_inc;
    logic             w_round_clr;
    logic             w_pulse_ok;
    logic [1:0]       w_enemy_pick;
    logic [1:0]       w_lfsr_pick;

    assign w_win  = bus.player_win | bus.enemy_win;
    assign w_term = (r_cnt == '0);
    assign w_illegal = ((bus.btn_code == 2'b10) && (bus.player_bats == 2'd0)) ||
                       ((bus.btn_code == 2'b11) && (bus.player_swords == 2'd0));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_refuse     = 1'b0;
        w_ehit_entry = 1'b0;
        w_round_inc  = 1'b0;
        w_round_clr  = 1'b0;
        if (!bus.battle_active) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_next      = S_WAIT;
                    w_round_clr = 1'b1;
                end
                S_WAIT: begin
                    if (bus.btn_valid) begin
                        if (w_illegal) begin
                            w_refuse = 1'b1;
                        end else begin
                            w_accept = 1'b1;
                            w_next   = S_PHIT;
                        end
                    end
                end
                S_PHIT: w_next = S_PDLY;
                S_PDLY: begin
                    if (w_term) begin
                        if (w_win) begin
                            w_next = S_DONE;
                        end else begin
                            w_next       = S_EHIT;
                            w_ehit_entry = 1'b1;
                        end
                    end
                end
                S_EHIT: w_next = S_EDLY;
                S_EDLY: begin
                    if (w_term) begin
                        if (w_win) begin
                            w_next = S_DONE;
                        end else begin
                            w_next      = S_WAIT;
                            w_round_inc = 1'b1;
                        end
                    end
                end
                S_DONE:  w_next = S_DONE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Down-counter loaded during the strike cycle; terminal count is zero.
    always_ff @(posedge clk) begin
        if (rst || !bus.battle_active) begin
            r_cnt <= '0;
        end else if (r_state == S_PHIT || r_state == S_EHIT) begin
            r_cnt <= CNT_W'(RESP_DELAY - 1);
        end else if ((r_state == S_PDLY || r_state == S_EDLY) && !w_term) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Galois LFSR, taps 16,14,13,11, free-running.
    always_ff @(posedge clk) begin
        if (rst) r_lfsr <= LFSR_SEED;
        else     r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    always_comb begin
        w_lfsr_pick = r_lfsr[1:0];
        if (w_lfsr_pick == 2'b10 && bus.enemy_bats == 2'd0)   w_lfsr_pick = 2'b00;
        if (w_lfsr_pick == 2'b11 && bus.enemy_swords == 2'd0) w_lfsr_pick = 2'b01;
    end

`ifdef ENEMY_SMART_EN
    always_comb begin
        w_enemy_pick = w_lfsr_pick;
        if (bus.player_hp <= 8'd40 && bus.enemy_swords != 2'd0)   w_enemy_pick = 2'b11;
        else if (bus.player_hp <= 8'd30 && bus.enemy_bats != 2'd0) w_enemy_pick = 2'b10;
    end
`else
    logic w_unused_hp;
    assign w_unused_hp  = ^bus.player_hp;
    assign w_enemy_pick = w_lfsr_pick;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_player_choice <= 2'b00;
            r_enemy_choice  <= 2'b00;
            r_reject        <= 1'b0;
            r_round         <= 8'd0;
        end else begin
            r_reject <= w_refuse;
            if (w_accept)     r_player_choice <= bus.btn_code;
            if (w_ehit_entry) r_enemy_choice  <= w_enemy_pick;
            if (w_round_clr)
                r_round <= 8'd0;
            else if (w_round_inc && r_round != 8'hFF)
                r_round <= r_round + 8'd1;
        end
    end

    // Strike pulses drop immediately when reset or loss of contact arrives mid-cycle.
    assign w_pulse_ok        = !rst && bus.battle_active;
    assign bus.player_turn   = (r_state == S_PHIT) && w_pulse_ok;
    assign bus.attacker_turn = (r_state == S_EHIT) && w_pulse_ok;
    assign bus.await_input   = (r_state == S_WAIT);
    assign bus.player_choice = r_player_choice;
    assign bus.enemy_choice  = r_enemy_choice;
    assign bus.reject        = r_reject;
    assign bus.round_count   = r_round;

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Directed bench for battle_turn_ctrl with RESP_DELAY=4 and a reference LFSR.
// Smart-enemy expectation follows ENEMY_SMART_EN when the bench is built with it.
module tb_battle_turn_ctrl;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   exp_round;

    logic [15:0] m_lfsr;
    logic [15:0] m_prev;

    battle_turn_if bif ();

    battle_turn_ctrl #(.RESP_DELAY(4), .CNT_W(27), .LFSR_SEED(16'hACE1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk) begin
        m_prev <= m_lfsr;
        m_lfsr <= rst ? 16'hACE1 : lfsr_step(m_lfsr);
    end

    function automatic logic [1:0] exp_enemy(input logic [15:0] l, input logic [1:0] eb,
                                             input logic [1:0] es, input logic [7:0] hp);
        logic [1:0] r;
`ifdef ENEMY_SMART_EN
        if (hp <= 8'd40 && es != 2'd0) return 2'b11;
        if (hp <= 8'd30 && eb != 2'd0) return 2'b10;
`endif
        r = l[1:0];
        if (r == 2'b10 && eb == 2'd0) r = 2'b00;
        if (r == 2'b11 && es == 2'd0) r = 2'b01;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press a legal key in S_WAIT and walk one full player+enemy round.
    task automatic do_round(input logic [1:0] code);
        logic [1:0] e;
        chk("await_before_press", bif.await_input, 8'd1);
        bif.btn_code  = code;
        bif.btn_valid = 1'b1;
        tick();
        bif.btn_valid = 1'b0;
        chk("player_turn", bif.player_turn, 8'd1);
        chk("player_choice", bif.player_choice, code);
        chk("attacker_lo_at_phit", bif.attacker_turn, 8'd0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("player_turn_lo", bif.player_turn, 8'd0);
            chk("attacker_turn", bif.attacker_turn, (k == 5) ? 8'd1 : 8'd0);
            chk("await_input", bif.await_input, (k == 10) ? 8'd1 : 8'd0);
            if (k == 5) begin
                e = exp_enemy(m_prev, bif.enemy_bats, bif.enemy_swords, bif.player_hp);
                chk("enemy_choice", bif.enemy_choice, e);
            end
        end
        exp_round = (exp_round == 255) ? 255 : exp_round + 1;
        chk("round_count", bif.round_count, exp_round[7:0]);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_round = 0;
        rst = 1'b1;
        bif.battle_active = 1'b0;
        bif.btn_valid     = 1'b0;
        bif.btn_code      = 2'b00;
        bif.player_bats   = 2'd2;
        bif.player_swords = 2'd2;
        bif.enemy_bats    = 2'd2;
        bif.enemy_swords  = 2'd2;
        bif.player_hp     = 8'd100;
        bif.player_win    = 1'b0;
        bif.enemy_win     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_player_turn", bif.player_turn, 8'd0);
        chk("rst_attacker_turn", bif.attacker_turn, 8'd0);
        chk("rst_await", bif.await_input, 8'd0);
        chk("rst_reject", bif.reject, 8'd0);
        chk("rst_round", bif.round_count, 8'd0);
        chk("rst_pchoice", bif.player_choice, 8'd0);
        chk("rst_echoice", bif.enemy_choice, 8'd0);

        tick();
        chk("idle_holds", bif.await_input, 8'd0);
        bif.battle_active = 1'b1;
        tick();
        chk("enter_wait", bif.await_input, 8'd1);

        do_round(2'b01);
        do_round(2'b10);

        bif.player_hp = 8'd35;
        do_round(2'b00);
        bif.player_hp = 8'd100;

        // Sword press with no swords left is refused.
        bif.player_swords = 2'd0;
        bif.btn_code  = 2'b11;
        bif.btn_valid = 1'b1;
        tick();
        bif.btn_valid = 1'b0;
        chk("reject_pulse", bif.reject, 8'd1);
        chk("reject_no_turn", bif.player_turn, 8'd0);
        chk("reject_stay_wait", bif.await_input, 8'd1);
        tick();
        chk("reject_one_cycle", bif.reject, 8'd0);
        chk("reject_no_turn2", bif.player_turn, 8'd0);
        chk("reject_choice_hold", bif.player_choice, 8'd0);
        bif.player_swords = 2'd2;

        // Enemy out of heavy weapons: only punch/kick, and round_count saturates.
        bif.enemy_bats   = 2'd0;
        bif.enemy_swords = 2'd0;
        for (int r = 0; r < 260; r++) begin
            do_round(2'b01);
            chk("enemy_light_only", {7'd0, bif.enemy_choice[1]}, 8'd0);
        end
        bif.enemy_bats   = 2'd2;
        bif.enemy_swords = 2'd2;

        // Win during player settle: no enemy strike, then frozen in S_DONE.
        bif.btn_code  = 2'b00;
        bif.btn_valid = 1'b1;
        tick();
        bif.btn_valid = 1'b0;
        chk("win_player_turn", bif.player_turn, 8'd1);
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 1) bif.player_win = 1'b1;
            if (k == 9) bif.player_win = 1'b0;
            chk("win_no_attacker", bif.attacker_turn, 8'd0);
            chk("win_no_player", bif.player_turn, 8'd0);
            chk("win_no_await", bif.await_input, 8'd0);
        end
        chk("win_round_hold", bif.round_count, 8'd255);
        bif.battle_active = 1'b0;
        tick();
        chk("idle_after_done", bif.await_input, 8'd0);
        chk("idle_round_hold", bif.round_count, 8'd255);
        bif.battle_active = 1'b1;
        tick();
        chk("rewait", bif.await_input, 8'd1);
        chk("round_cleared", bif.round_count, 8'd0);
        exp_round = 0;

        // Contact lost during the player strike cycle.
        bif.btn_code  = 2'b01;
        bif.btn_valid = 1'b1;
        tick();
        bif.btn_valid = 1'b0;
        chk("abort_pre_turn", bif.player_turn, 8'd1);
        bif.battle_active = 1'b0;
        #1;
        chk("abort_turn_suppressed", bif.player_turn, 8'd0);
        tick();
        chk("abort_idle", bif.await_input, 8'd0);
        chk("abort_choice_hold", bif.player_choice, 8'd1);
        tick();
        chk("abort_no_attacker", bif.attacker_turn, 8'd0);
        bif.battle_active = 1'b1;
        tick();
        chk("abort_rewait", bif.await_input, 8'd1);

        // Reset during the player strike cycle.
        bif.btn_code  = 2'b10;
        bif.btn_valid = 1'b1;
        tick();
        bif.btn_valid = 1'b0;
        chk("rst_mid_pre", bif.player_turn, 8'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_suppressed", bif.player_turn, 8'd0);
        tick();
        rst = 1'b0;
        chk("rst_mid_pchoice", bif.player_choice, 8'd0);
        chk("rst_mid_await", bif.await_input, 8'd0);
        chk("rst_mid_round", bif.round_count, 8'd0);
        chk("rst_mid_turn", bif.player_turn, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
